// File: rtl/pipe_ctrl_v2.sv
// pipe_ctrl_v2: control/hazard unit for a 5-stage RV32I pipeline (F/D/E/M/W).
// Tracks E/M/W control fields, resolves forwarding, hazards, redirects and the data-memory handshake.
module pipe_ctrl_v2 #(
    parameter int REG_IDX_W   = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int STAT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           D_op,
    input  logic [REG_IDX_W-1:0] D_rd,
    input  logic [REG_IDX_W-1:0] D_rs1,
    input  logic [REG_IDX_W-1:0] D_rs2,
    input  logic [2:0]           D_f3,
    input  logic                 D_f7,
    input  logic                 b,
    input  logic [1:0]           M_addr_lo,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 pc_hold,
    output logic                 next_pc_sel,
    output logic                 D_rs1_data_sel,
    output logic                 D_rs2_data_sel,
    output logic [1:0]           E_rs1_data_sel,
    output logic [1:0]           E_rs2_data_sel,
    output logic                 E_alu_op1_sel,
    output logic                 E_alu_op2_sel,
    output logic                 E_jb_op1_sel,
    output logic [4:0]           E_op_out,
    output logic [2:0]           E_f3_out,
    output logic                 E_f7_out,
    output logic [3:0]           M_dm_w_en,
    output logic                 W_wb_en,
    output logic                 W_wb_data_sel,
    output logic [REG_IDX_W-1:0] W_rd_index,
    output logic [2:0]           W_f3_out,
    output logic                 mem_err,
    output logic                 misalign,
    output logic [STAT_W-1:0]    stall_cnt
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_NOP    = 5'b00011;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R_TYPE = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    typedef struct packed {
        logic [4:0]           op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [2:0]           f3;
        logic                 f7;
    } stage_t;

    // M and W only need the fields consumed by the memory and write-back stages.
    typedef struct packed {
        logic [4:0]           op;
        logic [REG_IDX_W-1:0] rd;
        logic [2:0]           f3;
    } tail_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    localparam stage_t E_NOP = stage_t'{OP_NOP, '0, '0, '0, 3'b000, 1'b0};
    localparam tail_t  T_NOP = tail_t'{OP_NOP, '0, 3'b000};

    function automatic logic uses_rs1(input logic [4:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return (op == OP_R_TYPE || op == OP_STORE || op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        return !(op == OP_STORE || op == OP_BRANCH || op == OP_NOP);
    endfunction

    function automatic logic [1:0] fwd_src(input logic [REG_IDX_W-1:0] rs,
                                           input tail_t m, input tail_t w);
        if (writes_rd(m.op) && m.rd != '0 && m.rd == rs)
            return 2'd1;
        else if (writes_rd(w.op) && w.rd != '0 && w.rd == rs)
            return 2'd0;
        return 2'd2;
    endfunction

    stage_t            e_q, e_d, d_stage;
    tail_t             m_q, m_d, w_q, w_d;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        wen_q, wen_d, lane_wen;
    logic              mis_q, mis_d, lane_mis;
    logic [STAT_W-1:0] stall_q, stall_d;
    logic              m_mem, mem_busy, redirect, load_use;

    assign d_stage = stage_t'{D_op, D_rd, D_rs1, D_rs2, D_f3, D_f7};
    assign m_mem   = (m_q.op == OP_LOAD) || (m_q.op == OP_STORE);

    // A WAIT cycle that sees ready completes the access and lets the pipe advance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_busy = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m_mem && !dmem_ready) begin
                    state_d  = S_WAIT;
                    cnt_d    = 8'd1;
                    mem_busy = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d = S_IDLE;
                end else begin
                    mem_busy = 1'b1;
                    if (cnt_q == TIMEOUT_C)
                        state_d = S_ERR;
                    else
                        cnt_d = cnt_q + 8'd1;
                end
            end
            S_ERR:   mem_busy = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign redirect = (e_q.op == OP_JAL) || (e_q.op == OP_JALR) ||
                      ((e_q.op == OP_BRANCH) && b);
    assign load_use = (e_q.op == OP_LOAD) && (e_q.rd != '0) &&
                      ((uses_rs1(D_op) && D_rs1 == e_q.rd) ||
                       (uses_rs2(D_op) && D_rs2 == e_q.rd));

    always_comb begin
        e_d         = e_q;
        m_d         = m_q;
        w_d         = w_q;
        pc_hold     = 1'b0;
        next_pc_sel = 1'b1;
        if (mem_busy) begin
            w_d     = T_NOP;
            pc_hold = 1'b1;
        end else begin
            m_d = tail_t'{e_q.op, e_q.rd, e_q.f3};
            w_d = m_q;
            if (redirect) begin
                e_d         = E_NOP;
                next_pc_sel = 1'b0;
            end else if (load_use) begin
                e_d     = E_NOP;
                pc_hold = 1'b1;
            end else begin
                e_d = d_stage;
            end
        end
    end

    always_comb begin
        lane_wen = 4'b0000;
        lane_mis = 1'b0;
        if (m_q.op == OP_STORE) begin
            case (m_q.f3)
                3'b000: lane_wen = 4'b0001 << M_addr_lo;
                3'b001: begin
                    if (M_addr_lo[0]) lane_mis = 1'b1;
                    else              lane_wen = 4'b0011 << {M_addr_lo[1], 1'b0};
                end
                3'b010: begin
                    if (M_addr_lo != 2'b00) lane_mis = 1'b1;
                    else                    lane_wen = 4'b1111;
                end
                default: lane_wen = 4'b0000;
            endcase
        end
    end

    // Lane enables are frozen for the whole wait so the memory sees a stable request.
    always_comb begin
        wen_d = lane_wen;
        mis_d = lane_mis;
        if (state_q == S_WAIT) begin
            wen_d = wen_q;
            mis_d = mis_q;
        end else if (state_q == S_ERR) begin
            wen_d = 4'b0000;
            mis_d = 1'b0;
        end
    end

    assign stall_d = (pc_hold && stall_q != {STAT_W{1'b1}}) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            e_q     <= E_NOP;
            m_q     <= T_NOP;
            w_q     <= T_NOP;
            wen_q   <= '0;
            mis_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            wen_q   <= wen_d;
            mis_q   <= mis_d;
            stall_q <= stall_d;
        end
    end

    assign dmem_req       = m_mem && (state_q != S_ERR);
    assign mem_err        = (state_q == S_ERR);
    assign M_dm_w_en      = wen_d;
    assign misalign       = mis_d;
    assign stall_cnt      = stall_q;
    assign D_rs1_data_sel = writes_rd(w_q.op) && (w_q.rd != '0) && (w_q.rd == D_rs1);
    assign D_rs2_data_sel = writes_rd(w_q.op) && (w_q.rd != '0) && (w_q.rd == D_rs2);
    assign E_rs1_data_sel = fwd_src(e_q.rs1, m_q, w_q);
    assign E_rs2_data_sel = fwd_src(e_q.rs2, m_q, w_q);
    assign E_alu_op1_sel  = (e_q.op == OP_AUIPC) || (e_q.op == OP_JAL) || (e_q.op == OP_JALR);
    assign E_alu_op2_sel  = (e_q.op == OP_LOAD) || (e_q.op == OP_STORE) || (e_q.op == OP_IMM) ||
                            (e_q.op == OP_LUI) || (e_q.op == OP_AUIPC) ||
                            (e_q.op == OP_JAL) || (e_q.op == OP_JALR);
    assign E_jb_op1_sel   = (e_q.op == OP_JALR);
    assign E_op_out       = e_q.op;
    assign E_f3_out       = e_q.f3;
    assign E_f7_out       = e_q.f7;
    assign W_wb_en        = writes_rd(w_q.op);
    assign W_wb_data_sel  = (w_q.op == OP_LOAD);
    assign W_rd_index     = w_q.rd;
    assign W_f3_out       = w_q.f3;

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Randomised and directed bench for pipe_ctrl_v2, compared every cycle against a
// stage-list reference model built from the hazard, forwarding and memory rules.
module tb_pipe_ctrl_v2;

    localparam int RW        = 5;
    localparam int TMO       = 4;
    localparam int SW        = 4;
    localparam int STALL_MAX = (1 << SW) - 1;

    localparam int OP_LOAD = 0, OP_NOP = 3, OP_IMM = 4, OP_AUIPC = 5, OP_STORE = 8;
    localparam int OP_R = 12, OP_LUI = 13, OP_BRANCH = 24, OP_JALR = 25, OP_JAL = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    D_op = 5'(OP_NOP);
    logic [RW-1:0] D_rd = '0, D_rs1 = '0, D_rs2 = '0;
    logic [2:0]    D_f3 = '0;
    logic          D_f7 = 1'b0, b = 1'b0, dmem_ready = 1'b1;
    logic [1:0]    M_addr_lo = '0;
    logic          dmem_req, pc_hold, next_pc_sel, D_rs1_data_sel, D_rs2_data_sel;
    logic [1:0]    E_rs1_data_sel, E_rs2_data_sel;
    logic          E_alu_op1_sel, E_alu_op2_sel, E_jb_op1_sel;
    logic [4:0]    E_op_out;
    logic [2:0]    E_f3_out, W_f3_out;
    logic          E_f7_out, W_wb_en, W_wb_data_sel, mem_err, misalign;
    logic [3:0]    M_dm_w_en;
    logic [RW-1:0] W_rd_index;
    logic [SW-1:0] stall_cnt;

    pipe_ctrl_v2 #(.REG_IDX_W(RW), .MEM_TIMEOUT(TMO), .STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .D_op(D_op), .D_rd(D_rd), .D_rs1(D_rs1), .D_rs2(D_rs2),
        .D_f3(D_f3), .D_f7(D_f7), .b(b), .M_addr_lo(M_addr_lo), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_hold(pc_hold), .next_pc_sel(next_pc_sel),
        .D_rs1_data_sel(D_rs1_data_sel), .D_rs2_data_sel(D_rs2_data_sel),
        .E_rs1_data_sel(E_rs1_data_sel), .E_rs2_data_sel(E_rs2_data_sel),
        .E_alu_op1_sel(E_alu_op1_sel), .E_alu_op2_sel(E_alu_op2_sel), .E_jb_op1_sel(E_jb_op1_sel),
        .E_op_out(E_op_out), .E_f3_out(E_f3_out), .E_f7_out(E_f7_out), .M_dm_w_en(M_dm_w_en),
        .W_wb_en(W_wb_en), .W_wb_data_sel(W_wb_data_sel), .W_rd_index(W_rd_index),
        .W_f3_out(W_f3_out), .mem_err(mem_err), .misalign(misalign), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int op; int rd; int rs1; int rs2; int f3; int f7; } ins_t;

    ins_t st_e, st_m, st_w, cur_d;
    bit   err, last_mis, prev_hold;
    int   waited, stall, last_wen, cur_addr;
    int   n_checks = 0, n_errors = 0, cyc = 0;
    int   op_tab[10] = '{OP_LOAD, OP_NOP, OP_IMM, OP_AUIPC, OP_STORE, OP_R, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic ins_t nop_ins();
        ins_t n;
        n = '{OP_NOP, 0, 0, 0, 0, 0};
        return n;
    endfunction

    function automatic bit is_mem(int op);  return op == OP_LOAD || op == OP_STORE;                    endfunction
    function automatic bit uses1(int op);   return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);  endfunction
    function automatic bit uses2(int op);   return op == OP_R || op == OP_STORE || op == OP_BRANCH;   endfunction
    function automatic bit writes(int op);  return !(op == OP_STORE || op == OP_BRANCH || op == OP_NOP); endfunction

    function automatic int e_fwd(int rs);
        if (writes(st_m.op) && st_m.rd != 0 && st_m.rd == rs) return 1;
        if (writes(st_w.op) && st_w.rd != 0 && st_w.rd == rs) return 0;
        return 2;
    endfunction

    function automatic int d_byp(int rs);
        return (writes(st_w.op) && st_w.rd != 0 && st_w.rd == rs) ? 1 : 0;
    endfunction

    function automatic int lane_model(int f3, int a, output bit mis);
        mis = 1'b0;
        case (f3)
            0: return 1 << a;
            1: begin if (a % 2 != 0) begin mis = 1'b1; return 0; end return 3 << a; end
            2: begin if (a != 0) begin mis = 1'b1; return 0; end return 15; end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        st_e = nop_ins(); st_m = nop_ins(); st_w = nop_ins();
        err = 0; waited = 0; stall = 0; last_wen = 0; last_mis = 0; prev_hold = 0;
    endtask

    task automatic eval_and_step(input int bb, input int rdy);
        bit mem, busy, redir, lu, hold, mis;
        int wen;
        mem   = is_mem(st_m.op);
        busy  = err || (mem && rdy == 0);
        redir = (st_e.op == OP_JAL) || (st_e.op == OP_JALR) || (st_e.op == OP_BRANCH && bb != 0);
        lu    = (st_e.op == OP_LOAD) && st_e.rd != 0 &&
                ((uses1(cur_d.op) && cur_d.rs1 == st_e.rd) || (uses2(cur_d.op) && cur_d.rs2 == st_e.rd));
        hold  = busy || (!redir && lu);
        wen = 0; mis = 0;
        if (!err) begin
            if (waited > 0) begin wen = last_wen; mis = last_mis; end
            else if (st_m.op == OP_STORE) wen = lane_model(st_m.f3, cur_addr, mis);
        end
        check("pc_hold", int'(pc_hold), int'(hold));
        check("next_pc_sel", int'(next_pc_sel), (redir && !busy) ? 0 : 1);
        check("dmem_req", int'(dmem_req), int'(mem && !err));
        check("mem_err", int'(mem_err), int'(err));
        check("w_en", int'(M_dm_w_en), wen);
        check("misalign", int'(misalign), int'(mis));
        check("stall_cnt", int'(stall_cnt), stall);
        check("e_rs1_sel", int'(E_rs1_data_sel), e_fwd(st_e.rs1));
        check("e_rs2_sel", int'(E_rs2_data_sel), e_fwd(st_e.rs2));
        check("d_rs1_sel", int'(D_rs1_data_sel), d_byp(cur_d.rs1));
        check("d_rs2_sel", int'(D_rs2_data_sel), d_byp(cur_d.rs2));
        check("e_op", int'(E_op_out), st_e.op);
        check("e_f3", int'(E_f3_out), st_e.f3);
        check("e_f7", int'(E_f7_out), st_e.f7);
        check("alu1_sel", int'(E_alu_op1_sel), int'(st_e.op == OP_AUIPC || st_e.op == OP_JAL || st_e.op == OP_JALR));
        check("alu2_sel", int'(E_alu_op2_sel), int'(st_e.op != OP_R && st_e.op != OP_BRANCH && st_e.op != OP_NOP));
        check("jb1_sel", int'(E_jb_op1_sel), int'(st_e.op == OP_JALR));
        check("wb_en", int'(W_wb_en), int'(writes(st_w.op)));
        check("wb_sel", int'(W_wb_data_sel), int'(st_w.op == OP_LOAD));
        check("w_rd", int'(W_rd_index), st_w.rd);
        check("w_f3", int'(W_f3_out), st_w.f3);

        last_wen = wen; last_mis = mis;
        if (hold && stall < STALL_MAX) stall++;
        if (!err) begin
            if (mem && rdy == 0) begin
                if (waited == TMO) err = 1; else waited++;
            end else begin
                waited = 0;
            end
        end
        if (busy) begin
            st_w = nop_ins();
        end else begin
            st_w = st_m;
            st_m = st_e;
            if (redir || lu) st_e = nop_ins(); else st_e = cur_d;
        end
        prev_hold = hold;
    endtask

    task automatic cycle(input int op, input int rd, input int rs1, input int rs2, input int f3,
                         input int f7, input int bb, input int addr, input int rdy);
        @(negedge clk);
        cyc++;
        cur_d = '{op, rd, rs1, rs2, f3, f7};
        cur_addr = addr;
        D_op = 5'(op); D_rd = RW'(rd); D_rs1 = RW'(rs1); D_rs2 = RW'(rs2);
        D_f3 = 3'(f3); D_f7 = 1'(f7); b = 1'(bb); M_addr_lo = 2'(addr); dmem_ready = 1'(rdy);
        #1;
        $display("cyc %0d D_op=%0d b=%0d rdy=%0d a=%0d | E_op=%0d hold=%0b npc=%0b req=%0b wen=%b err=%0b st=%0d",
                 cyc, op, bb, rdy, addr, E_op_out, pc_hold, next_pc_sel, dmem_req, M_dm_w_en, mem_err, stall_cnt);
        eval_and_step(bb, rdy);
    endtask

    task automatic nop_cycle(input int rdy);
        cycle(OP_NOP, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        cyc++;
        rst_n = 1'b0;
        D_op = 5'(OP_NOP); D_rd = '0; D_rs1 = '0; D_rs2 = '0; D_f3 = '0; D_f7 = 1'b0;
        b = 1'b0; M_addr_lo = '0; dmem_ready = 1'b1;
        cur_d = nop_ins(); cur_addr = 0;
        #1;
        $display("cyc %0d reset asserted", cyc);
        model_reset();
        check("rst_next_pc_sel", int'(next_pc_sel), 1);
        check("rst_dmem_req", int'(dmem_req), 0);
        check("rst_mem_err", int'(mem_err), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        check("rst_w_en", int'(M_dm_w_en), 0);
        check("rst_pc_hold", int'(pc_hold), 0);
        check("rst_wb_en", int'(W_wb_en), 0);
        check("rst_e_op", int'(E_op_out), OP_NOP);
        #1 rst_n = 1'b1;
    endtask

    task automatic store_test(input int f3, input int addr, input int exp_wen, input int exp_mis);
        cycle(OP_STORE, 0, 1, 2, f3, 0, 0, 0, 1);
        nop_cycle(1);
        cycle(OP_NOP, 0, 0, 0, 0, 0, 0, addr, 1);
        check("store_w_en", int'(M_dm_w_en), exp_wen);
        check("store_misalign", int'(misalign), exp_mis);
    endtask

    initial begin
        int op, rd, rs1, rs2, f3, f7, err_age;
        reset_dut();

        // Back-to-back ALU forwarding, M over W, and x0 never forwarding.
        cycle(OP_R, 1, 2, 3, 0, 0, 0, 0, 1);
        cycle(OP_R, 2, 1, 1, 0, 0, 0, 0, 1);
        cycle(OP_R, 4, 1, 1, 0, 0, 0, 0, 1);
        check("fwd_m_rs1", int'(E_rs1_data_sel), 1);
        check("fwd_m_rs2", int'(E_rs2_data_sel), 1);
        cycle(OP_R, 0, 5, 6, 0, 0, 0, 0, 1);
        check("fwd_w_rs1", int'(E_rs1_data_sel), 0);
        cycle(OP_R, 7, 0, 0, 0, 0, 0, 0, 1);
        nop_cycle(1);
        check("fwd_x0_rs1", int'(E_rs1_data_sel), 2);

        // Load-use: one hold cycle, bubble in E, then bypass from W.
        cycle(OP_LOAD, 5, 1, 0, 2, 0, 0, 0, 1);
        cycle(OP_R, 6, 5, 0, 0, 0, 0, 0, 1);
        check("lu_hold", int'(pc_hold), 1);
        cycle(OP_R, 6, 5, 0, 0, 0, 0, 0, 1);
        check("lu_bubble", int'(E_op_out), OP_NOP);
        check("lu_release", int'(pc_hold), 0);
        nop_cycle(1);
        check("lu_fwd_w", int'(E_rs1_data_sel), 0);

        // Load waiting three cycles in M.
        reset_dut();
        cycle(OP_LOAD, 7, 1, 0, 2, 0, 0, 0, 1);
        cycle(OP_R, 8, 2, 3, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(OP_R, 9, 4, 5, 0, 0, 0, 0, 0);
        cycle(OP_R, 9, 4, 5, 0, 0, 0, 0, 1);
        nop_cycle(1);
        check("wait_stall_cnt", int'(stall_cnt), 3);
        check("wait_w_rd", int'(W_rd_index), 7);
        check("wait_w_sel", int'(W_wb_data_sel), 1);

        // Store lane enables and misalignment.
        store_test(0, 3, 4'b1000, 0);
        store_test(1, 2, 4'b1100, 0);
        store_test(1, 1, 4'b0000, 1);
        store_test(2, 0, 4'b1111, 0);
        store_test(2, 2, 4'b0000, 1);

        // Timeout into the sticky error state, counter saturation, reset clears it.
        reset_dut();
        cycle(OP_LOAD, 1, 2, 0, 2, 0, 0, 0, 1);
        nop_cycle(1);
        for (int i = 0; i < TMO + 1; i++) nop_cycle(0);
        nop_cycle(1);
        check("tmo_mem_err", int'(mem_err), 1);
        check("tmo_dmem_req", int'(dmem_req), 0);
        for (int i = 0; i < 16; i++) nop_cycle(i % 2);
        check("stall_saturate", int'(stall_cnt), STALL_MAX);
        reset_dut();
        check("tmo_cleared", int'(mem_err), 0);

        // Reset in the middle of a wait aborts the access.
        cycle(OP_STORE, 0, 1, 2, 2, 0, 0, 0, 1);
        nop_cycle(1);
        nop_cycle(0);
        nop_cycle(0);
        reset_dut();
        nop_cycle(1);
        check("abort_req", int'(dmem_req), 0);

        // Taken branch deferred behind a waiting load.
        reset_dut();
        cycle(OP_LOAD, 3, 1, 0, 2, 0, 0, 0, 1);
        cycle(OP_BRANCH, 0, 1, 2, 0, 0, 0, 0, 1);
        cycle(OP_R, 4, 5, 6, 0, 0, 1, 0, 0);
        check("br_defer_npc", int'(next_pc_sel), 1);
        cycle(OP_R, 4, 5, 6, 0, 0, 1, 0, 0);
        cycle(OP_R, 4, 5, 6, 0, 0, 1, 0, 1);
        check("br_taken_npc", int'(next_pc_sel), 0);
        nop_cycle(1);
        check("br_flush_e", int'(E_op_out), OP_NOP);

        // Randomised traffic; D is frozen while the previous cycle held the PC.
        reset_dut();
        err_age = 0;
        op = OP_NOP; rd = 0; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0;
        for (int i = 0; i < 400; i++) begin
            if (err) err_age++;
            if (err_age > 4 || $urandom_range(0, 149) == 0) begin
                reset_dut();
                err_age = 0;
            end
            if (!prev_hold) begin
                op  = op_tab[$urandom_range(0, 9)];
                rd  = $urandom_range(0, 7);
                rs1 = $urandom_range(0, 7);
                rs2 = $urandom_range(0, 7);
                f3  = $urandom_range(0, 3);
                f7  = $urandom_range(0, 1);
            end
            cycle(op, rd, rs1, rs2, f3, f7, $urandom_range(0, 1), $urandom_range(0, 3),
                  ($urandom_range(0, 3) != 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
